// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the alu_four sequencer slice
//
// Purpose: opcode constants, FSM state encoding and default datapath sizes
// shared by the sequencer, its register file and the instruction interface.
package alu_pkg;

  localparam int W_DEF    = 4;
  localparam int NREG_DEF = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  // Carry/borrow flag for a W-bit operation; and/or never set it.
  function automatic logic carry_flag(input logic [1:0] op,
                                      input logic [W_DEF-1:0] a,
                                      input logic [W_DEF-1:0] b);
    logic [W_DEF:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  return sum[W_DEF];
      OP_SUB:  return (a < b);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_four_if.sv
// rtl/alu_seq_four_if.sv - instruction handshake, writeback and flag bundle
//
// Purpose: groups the instruction-issue handshake, the writeback pulse and
// the flag register outputs of alu_seq_four.
// Signals:
//   in_valid/in_ready        instruction handshake
//   in_op/in_rd/in_rs1/in_rs2 instruction fields
//   done_valid/done_res      one-cycle writeback report
//   cf/sf/zf                 held flag registers
// Modports: master = instruction issuer, slave = sequencer.
interface alu_seq_four_if import alu_pkg::*; #(
  parameter int W  = W_DEF,
  parameter int AW = $clog2(NREG_DEF)
);

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;
  logic          done_valid;
  logic [W-1:0]  done_res;
  logic          cf;
  logic          sf;
  logic          zf;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  in_ready, done_valid, done_res, cf, sf, zf
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    output in_ready, done_valid, done_res, cf, sf, zf
  );

endinterface

// File: rtl/alu_regfile_four.sv
// rtl/alu_regfile_four.sv - NREG x W register file with writeback/load arbitration
//
// Purpose: operand store for the sequencer. Two combinational operand read
// ports, one combinational debug read port, and a single write path shared
// by ALU writeback and the external load strobe.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all entries)
//   ra1/rd1, ra2/rd2    operand read ports
//   dbg_addr/dbg_data   debug read port
//   wb_en/wb_addr/wb_data  ALU writeback
//   ld_en/ld_addr/ld_data  external load
module alu_regfile_four import alu_pkg::*; #(
  parameter  int W    = W_DEF,
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data
);

  logic [W-1:0] rf [NREG];

  // Writeback takes priority over a load to the same entry; loads to any
  // other entry still land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          rf[i] <= wb_data;
        end else if (ld_en && (ld_addr == AW'(i))) begin
          rf[i] <= ld_data;
        end
      end
    end
  end

  assign rd1      = rf[ra1];
  assign rd2      = rf[ra2];
  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_seq_four.sv
// rtl/alu_seq_four.sv - three-cycle instruction sequencer in front of alu_four
//
// Purpose: accepts register-to-register ALU instructions, reads operands
// from a local register file, presents them to the combinational ALU,
// captures the result, derives flags and writes the result back.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   bus (slave)                 instruction handshake, writeback report, flags
//   ld_en/ld_addr/ld_data       register file load port (any state)
//   dbg_addr/dbg_data           combinational register file read
//   alu_op/alu_a/alu_b          registered drive to the ALU
//   alu_res                     ALU result, sampled only in EXEC
module alu_seq_four import alu_pkg::*; #(
  parameter  int W    = W_DEF,
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_four_if.slave bus,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
  output logic [1:0]    alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_res
);

  state_t        state_q, state_d;
  logic          accept;
  logic          exec;
  logic          wb;
  logic [AW-1:0] rd_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  rf_rd1;
  logic [W-1:0]  rf_rd2;
  logic [W:0]    sum;
  logic          cf_d;

  alu_regfile_four #(.W(W), .NREG(NREG)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (bus.in_rs1),
    .ra2      (bus.in_rs2),
    .rd1      (rf_rd1),
    .rd2      (rf_rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wb_en    (wb),
    .wb_addr  (rd_q),
    .wb_data  (res_q),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    exec         = 1'b0;
    wb           = 1'b0;
    bus.in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec    = 1'b1;
        state_d = WB;
      end
      WB: begin
        wb      = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // alu_op/alu_a/alu_b double as the opcode and operand latch: they are
  // loaded at accept and held, so the flag logic reads them directly.
  assign sum = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    cf_d = 1'b0;
    case (alu_op)
      OP_ADD:  cf_d = sum[W];
      OP_SUB:  cf_d = (alu_a < alu_b);
      default: cf_d = 1'b0;
    endcase
  end

  // Flags and done_valid are registered at the end of EXEC so that they are
  // visible during the WB cycle, the same cycle the register file write
  // is committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q           <= '0;
      res_q          <= '0;
      alu_op         <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      bus.done_valid <= 1'b0;
      bus.done_res   <= '0;
      bus.cf         <= 1'b0;
      bus.sf         <= 1'b0;
      bus.zf         <= 1'b0;
    end else begin
      bus.done_valid <= exec;
      if (accept) begin
        rd_q   <= bus.in_rd;
        alu_op <= bus.in_op;
        alu_a  <= rf_rd1;
        alu_b  <= rf_rd2;
      end
      if (exec) begin
        res_q        <= alu_res;
        bus.done_res <= alu_res;
        bus.cf       <= cf_d;
        bus.sf       <= alu_res[W-1];
        bus.zf       <= (alu_res == '0);
      end
    end
  end

endmodule

// File: doc/alu_seq_four.md
Name: alu_seq_four

Overview:
Sequencer and operand store sitting directly upstream of the 4-bit combinational ALU (alu_four). It accepts register-to-register ALU instructions over a valid/ready handshake and reads operands from a 4-entry x 4-bit register file. It drives the ALU's opcode and operand inputs, captures the result, derives flags locally, and writes the result back. It also provides a load port and a debug read port for filling and inspecting the register file.

Parameters:
W, 4, datapath width; must match the ALU operand width.
NREG, 4, register file depth; addresses are clog2(NREG) = 2 bits.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous reset, active-low.
in_valid  in  1  instruction offered.
in_ready  out  1  instruction can be accepted; high only in IDLE.
in_op  in  2  ALU opcode: 00 and, 01 or, 10 add, 11 sub.
in_rd  in  2  destination register.
in_rs1  in  2  source register for operand a.
in_rs2  in  2  source register for operand b.
ld_en  in  1  load strobe.
ld_addr  in  2  load target register.
ld_data  in  W  load value.
dbg_addr  in  2  debug read address.
dbg_data  out  W  combinational value of rf[dbg_addr].
alu_op  out  2  to ALU opcode input.
alu_a  out  W  to ALU operand a.
alu_b  out  W  to ALU operand b.
alu_res  in  W  from ALU result; the ALU's flag outputs are not used.
done_valid  out  1  one-cycle pulse on writeback.
done_res  out  W  written-back result, valid while done_valid is high.
cf, sf, zf  out  1 each  flag register, updated at writeback and held otherwise.

Behaviour:
- Reset is asynchronous and active-low.
  - Register file entries, state, alu_op, alu_a, alu_b, done_valid, done_res, cf, sf and zf all reset to 0.
  - State resets to IDLE, so in_ready = 1 while and after reset.
- FSM: IDLE -> EXEC -> WB -> IDLE. There is no other state.
- Cycle T, IDLE, in_valid & in_ready:
  - Latch op and rd.
  - Latch a_q = rf[rs1] and b_q = rf[rs2]; reads see the pre-edge register contents (no load bypass).
  - Next state is EXEC.
- Cycle T+1, EXEC:
  - alu_op, alu_a and alu_b are registered outputs showing the latched op, a_q and b_q.
  - At the end of the cycle, capture res_q = alu_res and compute the flags.
- Flag rules:
  - zf = (res_q == 0); sf = res_q[W-1].
  - cf for add: carry out of the (W+1)-bit sum a_q + b_q.
  - cf for sub: borrow, i.e. a_q < b_q unsigned.
  - cf for and/or: 0.
- Cycle T+2, WB:
  - rf[rd] <= res_q.
  - done_valid = 1; done_res = res_q; cf/sf/zf registers updated.
  - Next state is IDLE.
- From T+3 in_ready = 1 again. Throughput is one instruction per 3 cycles; latency from accept to done_valid is 2 cycles.
- A held in_valid is not accepted in EXEC or WB. Instruction fields need only be stable in the accept cycle.
- All arithmetic is modulo 2^W; wrap-around is reflected only in cf.
- Loads:
  - ld_en writes rf[ld_addr] at any clock edge, in any state.
  - If ld_en and a WB write target the same register in the same cycle, the WB value wins and the load is dropped.
  - Different addresses are both written.
- Reset asserted mid-operation aborts the instruction: no done_valid pulse and no writeback. The register file is cleared.
- rd may equal rs1 or rs2; the operands were latched at accept, so there is no hazard.
- alu_res is sampled only in EXEC and ignored in every other state.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - the state encoding IDLE/EXEC/WB;
  - the W and NREG defaults.
- Natural sub-module: alu_regfile_four, a 4x4 register file with two combinational read ports, one debug read port, and a write port arbitrated between WB and load. The FSM, operand latch and flag logic stay in the top module.

Test Plan:
1. Reset, then load r0=1001, r1=1010; issue add rd=r2, rs1=r0, rs2=r1 -> done_valid 2 cycles after accept, done_res=0011, cf=1, sf=0, zf=0; dbg r2=0011.
2. sub rd=r3, rs1=r0, rs2=r1 -> done_res=1111, cf=1 (borrow), sf=1, zf=0. Then and r0, r1 -> 1000, cf=0, sf=1. Then or -> 1011.
3. Load r3=0101; and rd=r2, rs1=r1, rs2=r3 -> done_res=0000, zf=1, sf=0, cf=0; flags then hold for 5 idle cycles.
4. in_valid held high for 2 instructions -> second accepted exactly 3 cycles after the first; in_ready low in EXEC and WB; alu_a/alu_b correct in EXEC.
5. Collision: in the WB cycle of "add rd=r2", pulse ld_en to r2=0111 and, separately, to r1=0001 -> r2 holds the ALU result, r1=0001.
6. Drop rst_n during EXEC -> no done_valid, all dbg reads 0, in_ready=1, flags 0; a new instruction after release completes normally.
